prog_loader: RTL and testbench

Program-memory loader: the write side of the instruction store the fetch stage reads from. Accepts a byte stream (count header, instruction payload, XOR checksum) over a valid/ready handshake and emits one write per instruction into program memory from address 0 upward. Holds the CPU in reset (`CPU_HOLD`) while loading and reports `DONE` or `ERR` when the load ends.

---
 rtl/prog_loader.sv | 149 ++++++++++++++
 tb/tb_prog_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program-memory loader: takes a header/payload/checksum byte stream and writes
// one instruction per payload byte into program memory, holding the CPU in reset.
module prog_loader #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 START,
  input  logic                 IN_VALID,
  input  logic [7:0]           IN_DATA,
  output logic                 IN_READY,
  output logic                 MEM_WE,
  output logic [ADDR_SIZE-1:0] MEM_ADDR,
  output logic [DATA_SIZE-1:0] MEM_DATA,
  output logic                 CPU_HOLD,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR,
  output logic [2:0]           state_dbg
);

  // Handshake: a byte transfers on a rising edge when IN_VALID && IN_READY;
  // IN_READY is a function of state only and never looks at IN_VALID.

  localparam int CW = ADDR_SIZE + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_OK   = 3'd4,
    S_FAIL = 3'd5
  } state_t;

  state_t               state_q, state_n;
  logic [CW-1:0]        count_q, count_n;
  logic [ADDR_SIZE-1:0] addr_q, addr_n;
  logic [7:0]           chk_q, chk_n;
  logic                 we_q, we_n;
  logic [ADDR_SIZE-1:0] maddr_q, maddr_n;
  logic [DATA_SIZE-1:0] mdata_q, mdata_n;
  logic                 hold_q, hold_n;
  logic                 done_q, done_n;
  logic                 err_q, err_n;
  logic                 active;
  logic                 accept;

  assign active    = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign accept    = IN_VALID && active;
  assign IN_READY  = active;
  assign BUSY      = active;
  assign MEM_WE    = we_q;
  assign MEM_ADDR  = maddr_q;
  assign MEM_DATA  = mdata_q;
  assign CPU_HOLD  = hold_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign state_dbg = state_q;

  always_comb begin
    state_n = state_q;
    count_n = count_q;
    addr_n  = addr_q;
    chk_n   = chk_q;
    we_n    = 1'b0;
    maddr_n = maddr_q;
    mdata_n = mdata_q;
    hold_n  = hold_q;
    done_n  = done_q;
    err_n   = err_q;
    case (state_q)
      S_IDLE, S_OK, S_FAIL: begin
        if (START) begin
          done_n  = 1'b0;
          err_n   = 1'b0;
          hold_n  = 1'b1;
          state_n = S_HDR;
        end
      end
      S_HDR: begin
        if (accept) begin
          if (IN_DATA == 8'd0 || int'(IN_DATA) > (1 << ADDR_SIZE)) begin
            err_n   = 1'b1;
            state_n = S_FAIL;
          end else begin
            count_n = CW'(IN_DATA);
            addr_n  = '0;
            chk_n   = 8'd0;
            state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          we_n    = 1'b1;
          maddr_n = addr_q;
          mdata_n = IN_DATA[DATA_SIZE-1:0];
          // Upper bits are dropped from the write but still protected by the checksum.
          chk_n   = chk_q ^ IN_DATA;
          addr_n  = addr_q + 1'b1;
          count_n = count_q - 1'b1;
          if (count_q == CW'(1)) state_n = S_CHK;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (IN_DATA == chk_q) begin
            done_n  = 1'b1;
            hold_n  = 1'b0;
            state_n = S_OK;
          end else begin
            err_n   = 1'b1;
            state_n = S_FAIL;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      chk_q   <= 8'd0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      addr_q  <= addr_n;
      chk_q   <= chk_n;
      we_q    <= we_n;
      maddr_q <= maddr_n;
      mdata_q <= mdata_n;
      hold_q  <= hold_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: linear stimulus steps with immediate assertions,
// plus a write scoreboard fed with the expected (addr, data) pairs.
module tb_prog_loader;

  localparam int AW = 5;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          START;
  logic          IN_VALID;
  logic [7:0]    IN_DATA;
  logic          IN_READY;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_DATA;
  logic          CPU_HOLD;
  logic          BUSY;
  logic          DONE;
  logic          ERR;
  logic [2:0]    state_dbg;

  int tests = 0;
  int fails = 0;
  logic [AW+DW-1:0] exp_q[$];

  prog_loader #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
    .clk(clk), .rst(rst), .START(START), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .IN_READY(IN_READY), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .CPU_HOLD(CPU_HOLD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the next expected (addr, data) pair.
  always @(negedge clk) begin
    if (MEM_WE === 1'b1) begin
      logic [AW+DW-1:0] got, want;
      got = {MEM_ADDR, MEM_DATA};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL unexpected_write: observed %0h expected none", got);
      end else begin
        want = exp_q.pop_front();
        assert (got === want) else begin
          fails++;
          $error("FAIL write: observed %0h expected %0h", got, want);
        end
      end
    end
  end

  // Drivers
  task automatic send(input logic [7:0] b);
    bit accepted;
    accepted = 1'b0;
    IN_VALID = 1'b1;
    IN_DATA  = b;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (IN_READY === 1'b1) accepted = 1'b1;
      tick();
    end
    if (!accepted) check("send_ready", {31'd0, IN_READY}, 32'd1);
  endtask

  task automatic pay(input logic [AW-1:0] a, input logic [7:0] b);
    exp_q.push_back({a, b[DW-1:0]});
    send(b);
  endtask

  task automatic idle();
    IN_VALID = 1'b0;
    tick();
  endtask

  task automatic start_load();
    START = 1'b1;
    tick();
    START = 1'b0;
    check("start_busy", {31'd0, BUSY}, 32'd1);
    check("start_hold", {31'd0, CPU_HOLD}, 32'd1);
    check("start_ready", {31'd0, IN_READY}, 32'd1);
  endtask

  task automatic check_drained(input string tag);
    check(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] c;
    logic [7:0] b;
    rst = 1'b1; START = 1'b0; IN_VALID = 1'b0; IN_DATA = 8'd0;
    repeat (3) tick();
    check("rst_outputs", {24'd0, IN_READY, MEM_WE, BUSY, CPU_HOLD, DONE, ERR, 2'b00}, 32'd0);
    check("rst_addr", {27'd0, MEM_ADDR}, 32'd0);
    check("rst_data", {26'd0, MEM_DATA}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_ready", {31'd0, IN_READY}, 32'd0);

    // Good load, back-to-back
    start_load();
    send(8'h03);
    check("good_hdr_we", {31'd0, MEM_WE}, 32'd0);
    pay(5'd0, 8'h2A);
    check("good_w0", {20'd0, MEM_WE, MEM_ADDR, MEM_DATA}, {20'd0, 1'b1, 5'd0, 6'h2A});
    pay(5'd1, 8'h15);
    check("good_w1", {20'd0, MEM_WE, MEM_ADDR, MEM_DATA}, {20'd0, 1'b1, 5'd1, 6'h15});
    pay(5'd2, 8'h3F);
    check("good_w2", {20'd0, MEM_WE, MEM_ADDR, MEM_DATA}, {20'd0, 1'b1, 5'd2, 6'h3F});
    check("good_hold_pre", {31'd0, CPU_HOLD}, 32'd1);
    send(8'h00);
    check("good_done", {31'd0, DONE}, 32'd1);
    check("good_err", {31'd0, ERR}, 32'd0);
    check("good_hold_post", {31'd0, CPU_HOLD}, 32'd0);
    check("good_busy", {31'd0, BUSY}, 32'd0);
    check("good_ready", {31'd0, IN_READY}, 32'd0);
    check("good_we_after", {31'd0, MEM_WE}, 32'd0);
    idle();
    check_drained("good_drained");

    // Bad checksum, then a clean reload
    start_load();
    check("bad_done_cleared", {31'd0, DONE}, 32'd0);
    send(8'h03);
    pay(5'd0, 8'h2A);
    pay(5'd1, 8'h15);
    pay(5'd2, 8'h3F);
    send(8'h01);
    check("bad_err", {31'd0, ERR}, 32'd1);
    check("bad_done", {31'd0, DONE}, 32'd0);
    check("bad_hold", {31'd0, CPU_HOLD}, 32'd1);
    check("bad_busy", {31'd0, BUSY}, 32'd0);
    idle();
    start_load();
    check("reload_err_cleared", {31'd0, ERR}, 32'd0);
    send(8'h03);
    pay(5'd0, 8'h2A);
    pay(5'd1, 8'h15);
    pay(5'd2, 8'h3F);
    send(8'h00);
    check("reload_done", {31'd0, DONE}, 32'd1);
    idle();
    check_drained("bad_drained");

    // Header bounds
    start_load();
    send(8'h00);
    check("hdr0_err", {31'd0, ERR}, 32'd1);
    check("hdr0_busy", {31'd0, BUSY}, 32'd0);
    idle();
    idle();
    start_load();
    send(8'h21);
    check("hdr33_err", {31'd0, ERR}, 32'd1);
    check("hdr33_done", {31'd0, DONE}, 32'd0);
    idle();
    check_drained("hdr_bad_drained");
    start_load();
    send(8'h20);
    c = 8'h00;
    for (int i = 0; i < 32; i++) begin
      b = 8'(i * 37) ^ 8'hA5;
      c = c ^ b;
      pay(AW'(i), b);
    end
    check("hdr32_busy_before_chk", {31'd0, BUSY}, 32'd1);
    send(c);
    check("hdr32_done", {31'd0, DONE}, 32'd1);
    check("hdr32_err", {31'd0, ERR}, 32'd0);
    idle();
    check_drained("hdr32_drained");

    // Upper bits and stalls
    start_load();
    idle();
    send(8'h01);
    idle();
    pay(5'd0, 8'hC5);
    check("stall_w0", {20'd0, MEM_WE, MEM_ADDR, MEM_DATA}, {20'd0, 1'b1, 5'd0, 6'h05});
    idle();
    check("stall_gap_we", {31'd0, MEM_WE}, 32'd0);
    idle();
    send(8'hC5);
    check("stall_done", {31'd0, DONE}, 32'd1);
    idle();
    check_drained("stall_drained");

    // Reset mid-load
    start_load();
    send(8'h04);
    pay(5'd0, 8'h11);
    pay(5'd1, 8'h22);
    rst = 1'b1;
    IN_VALID = 1'b1;
    IN_DATA = 8'h33;
    tick();
    check("mid_rst_outputs", {24'd0, IN_READY, MEM_WE, BUSY, CPU_HOLD, DONE, ERR, 2'b00}, 32'd0);
    check("mid_rst_addr", {27'd0, MEM_ADDR}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("mid_rst_ready", {31'd0, IN_READY}, 32'd0);
    IN_VALID = 1'b0;
    idle();
    check_drained("mid_rst_drained");

    // START while busy is ignored
    start_load();
    send(8'h03);
    pay(5'd0, 8'h01);
    START = 1'b1;
    pay(5'd1, 8'h02);
    START = 1'b0;
    check("busy_start_state", {31'd0, BUSY}, 32'd1);
    pay(5'd2, 8'h04);
    send(8'h07);
    check("busy_start_done", {31'd0, DONE}, 32'd1);
    idle();
    idle();
    check_drained("busy_start_drained");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
